wm_phase_timer: RTL and testbench

WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

---
 rtl/wm_phase_timer.sv | 103 ++++++++++
 tb/tb_wm_phase_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_phase_timer.sv
// Phase timer for the washer controller: loads a tick budget on every state change,
// counts it down at clock/PRESCALE and pulses completion or timeout on expiry.
module wm_phase_timer #(
    parameter int PRESCALE   = 4,
    parameter int FILL_LIMIT = 60,
    parameter int HEAT_LIMIT = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] state,
    input  logic       sig_Lid_Closed,
    input  logic       cfg_Wr,
    input  logic [1:0] cfg_Addr,
    input  logic [7:0] cfg_Data,
    output logic       sig_Completed,
    output logic       sig_Time_Out,
    output logic [7:0] remaining,
    output logic       busy
);

    localparam logic [15:0] PS_MAX  = 16'(PRESCALE - 1);
    localparam logic [7:0]  FILL_LD = 8'(FILL_LIMIT);
    localparam logic [7:0]  HEAT_LD = 8'(HEAT_LIMIT);

    logic [2:0]  prev_state;
    logic [15:0] prescaler;
    logic [7:0]  counter;
    logic        expired;
    logic [7:0]  dur_wash, dur_rinse, dur_spin;
    logic        completed_q, time_out_q;

    logic       entry, timed, lid_gated, run_en, tick;
    logic [7:0] load_raw, load_val;

    always_comb begin
        entry     = (state != prev_state);
        timed     = (state >= 3'd2) && (state <= 3'd6);
        lid_gated = (state >= 3'd4) && (state <= 3'd6);
        load_raw  = 8'd0;
        case (state)
            3'd2:    load_raw = FILL_LD;
            3'd3:    load_raw = HEAT_LD;
            3'd4:    load_raw = dur_wash;
            3'd5:    load_raw = dur_rinse;
            3'd6:    load_raw = dur_spin;
            default: load_raw = 8'd0;
        endcase
        // A zero budget on a timed phase still runs one tick so it produces its pulse
        load_val = (timed && load_raw == 8'd0) ? 8'd1 : load_raw;
        run_en   = (counter != 8'd0) && timed && !entry && (!lid_gated || sig_Lid_Closed);
        tick     = run_en && (prescaler == PS_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_state  <= 3'd0;
            prescaler   <= 16'd0;
            counter     <= 8'd0;
            expired     <= 1'b0;
            completed_q <= 1'b0;
            time_out_q  <= 1'b0;
            dur_wash    <= 8'd30;
            dur_rinse   <= 8'd20;
            dur_spin    <= 8'd10;
        end else begin
            prev_state  <= state;
            completed_q <= 1'b0;
            time_out_q  <= 1'b0;
            if (entry) begin
                counter   <= load_val;
                prescaler <= 16'd0;
                expired   <= 1'b0;
            end else if (run_en) begin
                if (tick) begin
                    prescaler <= 16'd0;
                    counter   <= counter - 8'd1;
                    if (counter == 8'd1 && !expired) begin
                        expired     <= 1'b1;
                        completed_q <= lid_gated;
                        time_out_q  <= !lid_gated;
                    end
                end else begin
                    prescaler <= prescaler + 16'd1;
                end
            end
            // Writes land after the load mux has sampled the old value
            if (cfg_Wr) begin
                case (cfg_Addr)
                    2'd0:    dur_wash  <= cfg_Data;
                    2'd1:    dur_rinse <= cfg_Data;
                    2'd2:    dur_spin  <= cfg_Data;
                    default: ;
                endcase
            end
        end
    end

    assign sig_Completed = completed_q;
    assign sig_Time_Out  = time_out_q;
    assign remaining     = counter;
    assign busy          = (counter != 8'd0) && timed;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: elapsed-cycle reference model checked every cycle,
// directed phase scenarios with literal expectations, then randomized traffic.
module tb_wm_phase_timer;

    localparam int P    = 4;
    localparam int FILL = 60;
    localparam int HEAT = 120;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] state = 3'd0;
    logic       lid = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       sig_Completed, sig_Time_Out, busy;
    logic [7:0] remaining;

    wm_phase_timer #(.PRESCALE(P), .FILL_LIMIT(FILL), .HEAT_LIMIT(HEAT)) dut (
        .clock(clock), .reset_n(reset_n), .state(state), .sig_Lid_Closed(lid),
        .cfg_Wr(cfg_wr), .cfg_Addr(cfg_addr), .cfg_Data(cfg_data),
        .sig_Completed(sig_Completed), .sig_Time_Out(sig_Time_Out),
        .remaining(remaining), .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: a phase is a budget of load*P enabled cycles; remaining is the budget
    // minus whole ticks elapsed, and the pulse fires when the last enabled cycle lands.
    int m_prev, m_load, m_run;
    int m_dur[3];
    bit m_comp, m_to;

    function automatic int load_for(input int st);
        int v;
        case (st)
            2: v = FILL % 256;
            3: v = HEAT % 256;
            4, 5, 6: v = m_dur[st-4];
            default: return 0;
        endcase
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int m_rem();
        return m_load - m_run / P;
    endfunction

    always @(posedge clock) begin
        int st;
        st = int'(state);
        if (!reset_n) begin
            m_prev = 0; m_load = 0; m_run = 0; m_comp = 0; m_to = 0;
            m_dur[0] = 30; m_dur[1] = 20; m_dur[2] = 10;
        end else begin
            m_comp = 0;
            m_to   = 0;
            if (st != m_prev) begin
                m_load = load_for(st);
                m_run  = 0;
            end else if (m_rem() != 0 && st >= 2 && st <= 6 && (st < 4 || lid)) begin
                m_run++;
                if (m_run == m_load * P) begin
                    if (st >= 4) m_comp = 1;
                    else m_to = 1;
                end
            end
            if (cfg_wr && cfg_addr != 2'd3) m_dur[cfg_addr] = int'(cfg_data);
            m_prev = st;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("remaining", int'(remaining), m_rem());
            chk("sig_Completed", int'(sig_Completed), int'(m_comp));
            chk("sig_Time_Out", int'(sig_Time_Out), int'(m_to));
            chk("busy", int'(busy), int'(m_rem() != 0 && state >= 3'd2 && state <= 3'd6));
            chk("pulse_exclusive", int'(sig_Completed & sig_Time_Out), 0);
        end
    end

    task automatic tick_();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_wr = 1'b1; cfg_addr = 2'(a); cfg_data = 8'(d);
        tick_();
        cfg_wr = 1'b0;
    endtask

    initial begin
        int first, n, nc, r, k;
        reset_n = 1'b0;
        tick_();
        cmp_en = 1'b1;
        tick_();
        chk("reset_remaining", int'(remaining), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pulses", int'(sig_Completed | sig_Time_Out), 0);
        reset_n = 1'b1;
        tick_();

        // WASH=3: completion exactly 12 cycles after the load edge
        wr(0, 3);
        state = 3'd4;
        tick_();
        chk("wash_loaded", int'(remaining), 3);
        chk("wash_busy", int'(busy), 1);
        first = -1; n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick_();
            if (sig_Completed) begin n++; if (first < 0) first = i; end
        end
        chk("wash_done_cycle", first, 12);
        chk("wash_pulse_count", n, 1);
        chk("wash_end_remaining", int'(remaining), 0);

        // FILL timeout after 60*4 cycles
        state = 3'd2;
        tick_();
        first = -1; n = 0; nc = 0;
        for (int i = 1; i <= 260; i++) begin
            tick_();
            if (sig_Time_Out) begin n++; if (first < 0) first = i; end
            if (sig_Completed) nc++;
        end
        chk("fill_timeout_cycle", first, 240);
        chk("fill_timeout_count", n, 1);
        chk("fill_no_completed", nc, 0);

        // RINSE with a 9-cycle lid-open pause
        state = 3'd5;
        tick_();
        first = -1; r = 0;
        for (int i = 1; i <= 100; i++) begin
            tick_();
            if (i == 30) begin r = int'(remaining); lid = 1'b0; end
            if (i > 30 && i <= 39) chk("lid_frozen", int'(remaining), r);
            if (i == 39) lid = 1'b1;
            if (sig_Completed && first < 0) first = i;
        end
        chk("lid_remaining_at_pause", r, 13);
        chk("rinse_done_cycle", first, 89);

        // Entry on the cycle the final WASH tick would fire wins over the pulse
        state = 3'd4;
        tick_();
        for (int i = 1; i <= 11; i++) tick_();
        chk("wash_pre_final", int'(remaining), 1);
        state = 3'd5;
        tick_();
        chk("entry_beats_pulse", int'(sig_Completed), 0);
        chk("rinse_reloaded", int'(remaining), 20);

        // SPIN write mid-run does not disturb the running count
        state = 3'd6;
        tick_();
        first = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd5; end
            if (i == 6) cfg_wr = 1'b0;
            tick_();
            if (sig_Completed && first < 0) first = i;
        end
        chk("spin_old_run_cycle", first, 40);
        state = 3'd1;
        tick_();
        chk("ready_remaining", int'(remaining), 0);
        chk("ready_busy", int'(busy), 0);
        state = 3'd6;
        tick_();
        chk("spin_new_load", int'(remaining), 5);
        wr(2, 0);
        wr(3, 99);
        state = 3'd1; tick_();
        state = 3'd6; tick_();
        chk("spin_zero_clamp", int'(remaining), 1);
        state = 3'd1; tick_();
        state = 3'd6; cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd7;
        tick_();
        cfg_wr = 1'b0;
        chk("same_cycle_old_value", int'(remaining), 1);
        state = 3'd1; tick_();
        state = 3'd6; tick_();
        chk("spin_after_same_cycle", int'(remaining), 7);

        // Reset mid-HEAT aborts the count and restores durations
        state = 3'd3;
        tick_();
        k = 0;
        while (remaining != 8'd50 && k < 600) begin tick_(); k++; end
        chk("heat_reached_50", int'(remaining), 50);
        reset_n = 1'b0;
        tick_();
        chk("abort_remaining", int'(remaining), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_pulses", int'(sig_Completed | sig_Time_Out), 0);
        reset_n = 1'b1; state = 3'd0;
        tick_();
        chk("post_reset_no_load", int'(remaining), 0);
        state = 3'd4; tick_();
        chk("default_wash", int'(remaining), 30);
        state = 3'd5; tick_();
        chk("default_rinse", int'(remaining), 20);
        state = 3'd6; tick_();
        chk("default_spin", int'(remaining), 10);
        state = 3'd7; tick_();
        chk("fault_remaining", int'(remaining), 0);
        chk("fault_busy", int'(busy), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            lid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) state = 3'($urandom_range(0, 7));
            cfg_wr   = ($urandom_range(0, 9) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_data = 8'($urandom_range(0, 6));
            reset_n  = ($urandom_range(0, 499) != 0);
            tick_();
        end
        cfg_wr = 1'b0;
        reset_n = 1'b1;
        tick_();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
